// File: rtl/sprite_ram_loader.sv
// sprite_ram_loader: parses a MAGIC/width/height/pixel byte stream into sprite RAM writes
module sprite_ram_loader #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter logic [7:0] MAGIC = 8'hA5,
  parameter int X_W = $clog2(WIDTH),
  parameter int Y_W = $clog2(HEIGHT),
  parameter int AW  = $clog2(WIDTH*HEIGHT)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [7:0]    i_data,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic          i_abort,
  output logic [AW-1:0] o_wr_addr,
  output logic [11:0]   o_wr_data,
  output logic          o_wr_en,
  output logic [X_W-1:0] o_sprite_width,
  output logic [Y_W-1:0] o_sprite_height,
  output logic          o_sprite_valid,
  output logic          o_busy,
  output logic          o_error
);
  localparam int TW = AW + 1;
  localparam logic [3:0] IDLE = 4'd0, W_LO = 4'd1, W_HI = 4'd2, H_LO = 4'd3, H_HI = 4'd4,
                         CHECK = 4'd5, PIX_HI = 4'd6, PIX_LO = 4'd7, DONE = 4'd8;
  localparam logic [15:0] W_MAX = 16'(WIDTH);
  localparam logic [15:0] H_MAX = 16'(HEIGHT);
  localparam logic [16:0] W_LIM = 17'(1 << X_W);
  localparam logic [16:0] H_LIM = 17'(1 << Y_W);
  logic [3:0]    r_state;
  logic [15:0]   r_w, r_h;
  logic [TW-1:0] r_total;
  logic [AW-1:0] r_cnt;
  logic [3:0]    r_r;
  logic [AW-1:0] r_wr_addr;
  logic [11:0]   r_wr_data;
  logic          r_wr_en, r_sv, r_err;
  logic [X_W-1:0] r_sw;
  logic [Y_W-1:0] r_sh;
  logic          w_acc, w_bad, w_last;
  logic [31:0]   w_prod;
  // handshake, header validation and last-pixel detection
  always_comb begin
    o_ready = !i_reset && r_state != CHECK && r_state != DONE;
    w_acc   = i_valid && o_ready;
    w_bad   = r_w == 16'd0 || r_h == 16'd0 || r_w > W_MAX || r_h > H_MAX ||
              {1'b0, r_w} >= W_LIM || {1'b0, r_h} >= H_LIM;
    w_prod  = 32'(r_w) * 32'(r_h);
    w_last  = {1'b0, r_cnt} == r_total - TW'(1);
  end
  // load FSM; abort wins over any byte accepted in the same cycle
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_w       <= '0;
      r_h       <= '0;
      r_total   <= '0;
      r_cnt     <= '0;
      r_r       <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_en   <= 1'b0;
      r_sw      <= '0;
      r_sh      <= '0;
      r_sv      <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      if (i_abort) r_state <= IDLE;
      else case (r_state)
        IDLE: if (w_acc && i_data == MAGIC) begin
          r_state <= W_LO;
          r_sv    <= 1'b0;
          r_err   <= 1'b0;
        end
        W_LO: if (w_acc) begin r_w[7:0]  <= i_data; r_state <= W_HI; end
        W_HI: if (w_acc) begin r_w[15:8] <= i_data; r_state <= H_LO; end
        H_LO: if (w_acc) begin r_h[7:0]  <= i_data; r_state <= H_HI; end
        H_HI: if (w_acc) begin r_h[15:8] <= i_data; r_state <= CHECK; end
        CHECK: if (w_bad) begin
          r_err   <= 1'b1;
          r_state <= IDLE;
        end else begin
          r_total <= w_prod[TW-1:0];
          r_cnt   <= '0;
          r_state <= PIX_HI;
        end
        PIX_HI: if (w_acc) begin r_r <= i_data[3:0]; r_state <= PIX_LO; end
        PIX_LO: if (w_acc) begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_cnt;
          r_wr_data <= {r_r, i_data};
          r_cnt     <= r_cnt + 1'b1;
          r_state   <= w_last ? DONE : PIX_HI;
        end
        DONE: begin
          r_sw    <= r_w[X_W-1:0];
          r_sh    <= r_h[Y_W-1:0];
          r_sv    <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign o_wr_addr       = r_wr_addr;
  assign o_wr_data       = r_wr_data;
  assign o_wr_en         = r_wr_en;
  assign o_sprite_width  = r_sw;
  assign o_sprite_height = r_sh;
  assign o_sprite_valid  = r_sv;
  assign o_busy          = r_state != IDLE;
  assign o_error         = r_err;
endmodule

// File: tb/tb_sprite_ram_loader.sv
// tb_sprite_ram_loader: scoreboard bench for the sprite RAM loader
module tb_sprite_ram_loader;
  logic        clk = 1'b0;
  logic        i_reset, i_valid, i_abort, o_ready, o_wr_en, o_sprite_valid, o_busy, o_error;
  logic [7:0]  i_data;
  logic [18:0] o_wr_addr;
  logic [11:0] o_wr_data;
  logic [9:0]  o_sprite_width;
  logic [8:0]  o_sprite_height;
  int n_chk = 0, n_err = 0, n_nr = 0;
  logic [30:0] sb[$];
  logic [30:0] e;
  logic prev_wr = 1'b0, prev_sv = 1'b0;
  logic [15:0] last_w = 0, last_h = 0;
  logic [11:0] t1[6] = '{12'hFFF, 12'h456, 12'h789, 12'hABC, 12'hDEF, 12'h123};

  sprite_ram_loader dut (
    .i_clk(clk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .i_abort(i_abort), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_wr_en(o_wr_en),
    .o_sprite_width(o_sprite_width), .o_sprite_height(o_sprite_height),
    .o_sprite_valid(o_sprite_valid), .o_busy(o_busy), .o_error(o_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({o_ready, o_wr_addr, o_wr_data, o_wr_en, o_sprite_width, o_sprite_height,
                o_sprite_valid, o_busy, o_error});
  endfunction

  // write monitor: every strobe must match the oldest expected write
  always @(negedge clk) begin
    if (!i_reset && !o_ready) n_nr++;
    if (o_wr_en) begin
      chk("wr_pulse", 64'(prev_wr), 0);
      if (sb.size() == 0) chk("unexp_wr", 64'(o_wr_en), 0);
      else begin
        e = sb.pop_front();
        chk("wr_addr", 64'(o_wr_addr), 64'(e[30:12]));
        chk("wr_data", 64'(o_wr_data), 64'(e[11:0]));
      end
    end
    if (o_sprite_valid && !prev_sv) chk("sv_timing", 64'(prev_wr), 1);
    prev_wr = o_wr_en;
    prev_sv = o_sprite_valid;
  end

  task automatic send(input logic [7:0] b, input bit gap);
    int t;
    @(negedge clk);
    if (gap) repeat ($urandom_range(0, 2)) @(negedge clk);
    i_data = b;
    i_valid = 1'b1;
    t = 0;
    while (!o_ready && t < 20) begin @(negedge clk); t++; end
    if (t == 20) chk("ready_timeout", 64'(o_ready), 1);
    @(posedge clk);
    #1 i_valid = 1'b0;
    i_data = 8'($urandom);
  endtask

  task automatic hdr(input logic [15:0] w, input logic [15:0] h, input bit gap);
    send(8'hA5, gap); send(w[7:0], gap); send(w[15:8], gap); send(h[7:0], gap); send(h[15:8], gap);
  endtask

  task automatic pix(input int i, input logic [11:0] p, input bit gap, input bit clean);
    sb.push_back({19'(i), p});
    send({clean ? 4'h0 : 4'($urandom), p[11:8]}, gap);
    send(p[7:0], gap);
  endtask

  task automatic load(input logic [15:0] w, input logic [15:0] h, input bit gap, input bit tbl);
    int nr0, t;
    nr0 = n_nr;
    hdr(w, h, gap);
    for (int i = 0; i < int'(w) * int'(h); i++) pix(i, tbl ? t1[i] : 12'($urandom), gap, tbl);
    t = 0;
    while (!o_sprite_valid && t < 20) begin @(negedge clk); t++; end
    chk("load_sv", 64'(o_sprite_valid), 1);
    chk("load_w", 64'(o_sprite_width), 64'(w));
    chk("load_h", 64'(o_sprite_height), 64'(h));
    chk("load_busy", 64'(o_busy), 0);
    chk("load_err", 64'(o_error), 0);
    chk("load_sb", 64'(sb.size()), 0);
    chk("load_notready", 64'(n_nr - nr0), 2);
    last_w = w;
    last_h = h;
  endtask

  task automatic rej(input logic [15:0] w, input logic [15:0] h);
    int nr0;
    nr0 = n_nr;
    hdr(w, h, 1'b0);
    repeat (4) @(negedge clk);
    chk("rej_err", 64'(o_error), 1);
    chk("rej_busy", 64'(o_busy), 0);
    chk("rej_sv", 64'(o_sprite_valid), 0);
    chk("rej_w_hold", 64'(o_sprite_width), 64'(last_w));
    chk("rej_h_hold", 64'(o_sprite_height), 64'(last_h));
    chk("rej_notready", 64'(n_nr - nr0), 1);
  endtask

  initial begin
    i_reset = 1'b1; i_valid = 1'b0; i_abort = 1'b0; i_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), 0);
    i_reset = 1'b0;
    load(3, 2, 1'b0, 1'b1);
    send(8'h00, 1'b0);
    send(8'h11, 1'b0);
    load(3, 2, 1'b0, 1'b1);
    rej(16'h0281, 1);
    rej(0, 5);
    rej(4, 481);
    rej(3, 0);
    load(640, 1, 1'b0, 1'b0);
    load(16'h00A5, 1, 1'b0, 1'b0);
    load(5, 4, 1'b1, 1'b0);
    hdr(3, 2, 1'b0);
    for (int i = 0; i < 3; i++) pix(i, t1[i], 1'b0, 1'b1);
    send({4'h0, t1[3][11:8]}, 1'b0);
    @(negedge clk);
    i_data = t1[3][7:0];
    i_valid = 1'b1;
    i_abort = 1'b1;
    @(posedge clk);
    #1 i_abort = 1'b0;
    i_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy", 64'(o_busy), 0);
    chk("abort_sv", 64'(o_sprite_valid), 0);
    chk("abort_err", 64'(o_error), 0);
    chk("abort_sb", 64'(sb.size()), 0);
    load(3, 2, 1'b0, 1'b1);
    hdr(3, 2, 1'b0);
    for (int i = 0; i < 2; i++) pix(i, t1[i], 1'b0, 1'b1);
    send({4'h0, t1[2][11:8]}, 1'b0);
    @(negedge clk);
    #2 i_reset = 1'b1;
    #1 chk("reset_async", outs(), 0);
    @(negedge clk);
    i_reset = 1'b0;
    chk("reset_sb", 64'(sb.size()), 0);
    last_w = 0;
    last_h = 0;
    load(4, 3, 1'b1, 1'b0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
